ps2_rx_frame: RTL

//  Receives device-to-host PS/2 keyboard frames on PS2_CLK1/PS2_DATA1 for Top.
//  - Synchronises and deglitches the lines, then deserialises 11-bit frames: start, 8 data LSB-first, odd parity, stop.
//  - Delivers each byte with a one-cycle strobe to the scan-code/LED logic downstream.
//  - Flags parity, framing and timeout errors so the keyboard reset/echo logic can react.

---
 rtl/ps2_rx_frame.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: line sync, clock deglitch, 11-bit deserialiser
// with parity/framing/timeout error strobes.
module ps2_rx_frame #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       PS2_CLK1,
  input  logic       PS2_DATA1,
  input  logic       en,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TO_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FL_W-1:0] fcnt_q, fcnt_d;
  logic            fall;

  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  // Filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FL_W'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    to_cnt_d = (!en || state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;

    if (!en) begin
      state_d = S_IDLE;
    end else if (state_q != S_IDLE && to_cnt_q == TO_W'(TO_CYC)) begin
      ferr_d  = 1'b1;
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          sr_d     = {dat_s2_q, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (^{sr_q, par_q} == 1'b0) begin
            perr_d = 1'b1;
          end else begin
            data_d  = sr_q;
            valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      sr_q     <= 8'h00;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      clk_s1_q <= PS2_CLK1;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA1;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      to_cnt_q <= to_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
